// File: rtl/pid_pkg.sv
// Shared widths, FSM encoding and saturating helpers for the PID sequencer.
package pid_pkg;

    localparam int unsigned ERR_W     = 24;
    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned OUT_W     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StErr,
        StMp,
        StMi,
        StMd,
        StAcc,
        StOut
    } pid_state_e;

    // Three spare bits keep the sum of three products from overflowing.
    function automatic int unsigned acc_width(input int unsigned gain_w);
        return ERR_W + gain_w + 4;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                 input logic signed [63:0] lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/pid_shared_mult.sv
// Registered signed multiplier shared by the P, I and D terms; one-cycle latency.
module pid_shared_mult #(
    parameter int unsigned GAIN_W = 16,
    parameter int unsigned OPND_W = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [GAIN_W-1:0]               gain,
    input  logic signed [OPND_W-1:0]        opnd,
    output logic signed [GAIN_W+OPND_W:0]   prod
);
    localparam int unsigned PROD_W = GAIN_W + OPND_W + 1;

    logic signed [GAIN_W:0] gain_s;

    // Gains are unsigned; a zero MSB lets them enter a signed product.
    assign gain_s = {1'b0, gain};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod <= '0;
        end else begin
            prod <= PROD_W'(gain_s) * PROD_W'(opnd);
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// Per-sample PID controller: sequences P, I and D through one shared multiplier
// and emits a saturated control word with a fixed six-cycle valid latency.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int unsigned POS_W   = 32,
    parameter int unsigned GAIN_W  = 16,
    parameter int          INT_LIM = 2**20
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_aresetn,
    input  logic                     enable,
    input  logic                     sample_tick,
    input  logic [GAIN_W-1:0]        kp_init,
    input  logic [GAIN_W-1:0]        ki_init,
    input  logic [GAIN_W-1:0]        kd_init,
    input  logic signed [POS_W-1:0]  desired_pos,
    input  logic signed [POS_W-1:0]  actual_pos,
    input  logic                     clr_overrun,
    output logic signed [OUT_W-1:0]  u_out,
    output logic                     u_valid,
    output logic                     busy,
    output logic                     overrun
);
    localparam int unsigned PROD_W = ERR_W + GAIN_W + 1;
    localparam int unsigned ACC_W  = acc_width(GAIN_W);

    pid_state_e state_q, state_d;

    logic signed [POS_W-1:0]  des_q, act_q;
    logic signed [ERR_W-1:0]  e_q, e_prev_q, integ_q;
    logic signed [ERR_W-1:0]  e_new, integ_new, d_val, m_opnd;
    logic [GAIN_W-1:0]        m_gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, prod_ext;
    logic signed [OUT_W-1:0]  u_out_q, u_sat;
    logic                     u_valid_q, overrun_q;

    assign busy    = (state_q != StIdle);
    assign u_out   = u_out_q;
    assign u_valid = u_valid_q;
    assign overrun = overrun_q;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) state_q <= StIdle;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (sample_tick) state_d = StErr;
                StErr:   state_d = StMp;
                StMp:    state_d = StMi;
                StMi:    state_d = StMd;
                StMd:    state_d = StAcc;
                StAcc:   state_d = StOut;
                StOut:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        e_new     = ERR_W'(sat(64'(des_q) - 64'(act_q), ERR_W));
        integ_new = ERR_W'(clamp(64'(integ_q) + 64'(e_q), 64'(INT_LIM)));
        d_val     = ERR_W'(sat(64'(e_q) - 64'(e_prev_q), ERR_W));
        prod_ext  = ACC_W'(prod);
        u_sat     = OUT_W'(sat(64'(acc_q >>> FRAC_BITS), OUT_W));
    end

    // Operand mux: each issue state feeds its gain and term to the multiplier.
    always_comb begin
        m_gain = '0;
        m_opnd = '0;
        case (state_q)
            StMp: begin m_gain = kp_init; m_opnd = e_q;       end
            StMi: begin m_gain = ki_init; m_opnd = integ_new; end
            StMd: begin m_gain = kd_init; m_opnd = d_val;     end
            default: ;
        endcase
    end

    pid_shared_mult #(
        .GAIN_W (GAIN_W),
        .OPND_W (ERR_W)
    ) u_mult (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .gain  (m_gain),
        .opnd  (m_opnd),
        .prod  (prod)
    );

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            des_q     <= '0;
            act_q     <= '0;
            e_q       <= '0;
            e_prev_q  <= '0;
            integ_q   <= '0;
            acc_q     <= '0;
            u_out_q   <= '0;
            u_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            u_valid_q <= 1'b0;
            // A tick landing mid-sequence is dropped but remembered; set beats clear.
            if (sample_tick && state_q != StIdle) overrun_q <= 1'b1;
            else if (clr_overrun)                 overrun_q <= 1'b0;

            if (!enable) begin
                integ_q  <= '0;
                e_prev_q <= '0;
                u_out_q  <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (sample_tick) begin
                            des_q <= desired_pos;
                            act_q <= actual_pos;
                        end
                    end
                    StErr: e_q <= e_new;
                    StMi: begin
                        integ_q <= integ_new;
                        acc_q   <= prod_ext;
                    end
                    StMd: begin
                        acc_q    <= acc_q + prod_ext;
                        e_prev_q <= e_q;
                    end
                    StAcc: acc_q <= acc_q + prod_ext;
                    StOut: begin
                        u_out_q   <= u_sat;
                        u_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed self-checking bench for pid_sequencer; a second instance uses INT_LIM=25.
module tb_pid_sequencer;

    logic               clk = 1'b0;
    logic               aresetn;
    logic               enable;
    logic               sample_tick;
    logic [15:0]        kp, ki, kd;
    logic signed [31:0] desired_pos, actual_pos;
    logic               clr_overrun;
    logic signed [15:0] u_out, u_out_l;
    logic               u_valid, u_valid_l;
    logic               busy, busy_l;
    logic               overrun, overrun_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pid_sequencer dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .enable          (enable),
        .sample_tick     (sample_tick),
        .kp_init         (kp),
        .ki_init         (ki),
        .kd_init         (kd),
        .desired_pos     (desired_pos),
        .actual_pos      (actual_pos),
        .clr_overrun     (clr_overrun),
        .u_out           (u_out),
        .u_valid         (u_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    pid_sequencer #(.INT_LIM(25)) dut_lim (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .enable          (enable),
        .sample_tick     (sample_tick),
        .kp_init         (kp),
        .ki_init         (ki),
        .kd_init         (kd),
        .desired_pos     (desired_pos),
        .actual_pos      (actual_pos),
        .clr_overrun     (clr_overrun),
        .u_out           (u_out_l),
        .u_valid         (u_valid_l),
        .busy            (busy_l),
        .overrun         (overrun_l)
    );

    // Pulse one tick and watch 21 cycles; lat counts edges from the sampling edge.
    task automatic do_sample(output int lat, output int busy_cnt, output int nvalid,
                             output int v, output int v_lim);
        lat = -1; busy_cnt = 0; nvalid = 0; v = 0; v_lim = 0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        if (busy) busy_cnt++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (u_valid) nvalid++;
            if (u_valid && lat < 0) begin lat = i; v = int'(u_out); end
            if (u_valid_l) v_lim = int'(u_out_l);
        end
    endtask

    task automatic clear_loop();
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b0; sample_tick = 1'b0; clr_overrun = 1'b0;
        kp = '0; ki = '0; kd = '0; desired_pos = '0; actual_pos = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (u_out !== 16'sd0) begin errors++; $display("FAIL reset_u_out: got %0d want 0", u_out); end
        checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL reset_u_valid: got %b want 0", u_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (busy_l !== 1'b0 || overrun_l !== 1'b0 || u_out_l !== 16'sd0) begin
            errors++; $display("FAIL reset_lim: busy=%b overrun=%b u_out=%0d want 0/0/0", busy_l, overrun_l, u_out_l);
        end
        aresetn = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_p_only();
        int lat, bc, nv, v, vl;
        clear_loop();
        kp = 16'd256; ki = '0; kd = '0; desired_pos = 1000; actual_pos = 0;
        do_sample(lat, bc, nv, v, vl);
        checks++; if (lat != 6) begin errors++; $display("FAIL p_latency: got %0d want 6", lat); end
        checks++; if (bc != 6) begin errors++; $display("FAIL p_busy_cycles: got %0d want 6", bc); end
        checks++; if (nv != 1) begin errors++; $display("FAIL p_valid_count: got %0d want 1", nv); end
        checks++; if (v != 1000) begin errors++; $display("FAIL p_value: got %0d want 1000", v); end
        checks++; if (u_out !== 16'sd1000) begin errors++; $display("FAIL p_hold: got %0d want 1000", u_out); end
    endtask

    task automatic test_saturation();
        int lat, bc, nv, v, vl;
        kp = 16'd4096; ki = '0; kd = '0; desired_pos = 10000; actual_pos = 0;
        do_sample(lat, bc, nv, v, vl);
        checks++; if (v != 32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", v); end
        desired_pos = -10000;
        do_sample(lat, bc, nv, v, vl);
        checks++; if (v != -32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", v); end
    endtask

    task automatic test_integrator();
        int lat, bc, nv, v, vl;
        int exp_v [3] = '{10, 20, 30};
        int exp_l [3] = '{10, 20, 25};
        clear_loop();
        kp = '0; ki = 16'd256; kd = '0; desired_pos = 10; actual_pos = 0;
        for (int k = 0; k < 3; k++) begin
            do_sample(lat, bc, nv, v, vl);
            checks++; if (v != exp_v[k]) begin errors++; $display("FAIL integ_%0d: got %0d want %0d", k, v, exp_v[k]); end
            checks++; if (vl != exp_l[k]) begin errors++; $display("FAIL integ_lim_%0d: got %0d want %0d", k, vl, exp_l[k]); end
        end
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (u_out !== 16'sd0) begin errors++; $display("FAIL integ_disable_clear: got %0d want 0", u_out); end
        enable = 1'b1;
        do_sample(lat, bc, nv, v, vl);
        checks++; if (v != 10) begin errors++; $display("FAIL integ_restart: got %0d want 10", v); end
        checks++; if (vl != 10) begin errors++; $display("FAIL integ_lim_restart: got %0d want 10", vl); end
    endtask

    task automatic test_derivative();
        int lat, bc, nv, v, vl;
        int err_in [3] = '{5, 5, 2};
        int exp_v  [3] = '{5, 0, -3};
        clear_loop();
        kp = '0; ki = '0; kd = 16'd256; actual_pos = 0;
        for (int k = 0; k < 3; k++) begin
            desired_pos = err_in[k];
            do_sample(lat, bc, nv, v, vl);
            checks++; if (v != exp_v[k]) begin errors++; $display("FAIL deriv_%0d: got %0d want %0d", k, v, exp_v[k]); end
        end
    endtask

    task automatic test_overrun();
        int nv;
        clear_loop();
        kp = 16'd256; ki = '0; kd = '0; desired_pos = 100; actual_pos = 0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (u_valid) nv++;
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL overrun_valid_count: got %0d want 1", nv); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 sample_tick = 1'b1; clr_overrun = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0; clr_overrun = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b want 1", overrun); end
        repeat (10) @(posedge clk);
        #1 clr_overrun = 1'b1;
        @(posedge clk); #1 clr_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, nv, v, vl;
        clear_loop();
        kp = 16'd256; ki = '0; kd = '0; desired_pos = 1000; actual_pos = 0;
        do_sample(lat, bc, nv, v, vl);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 aresetn = 1'b0;
        @(posedge clk); #1;
        checks++; if (u_out !== 16'sd0) begin errors++; $display("FAIL rst_abort_u_out: got %0d want 0", u_out); end
        checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL rst_abort_u_valid: got %b want 0", u_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_abort_overrun: got %b want 0", overrun); end
        aresetn = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (u_valid) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL rst_abort_no_valid: got %0d want 0", nv); end
    endtask

    task automatic test_enable_abort();
        int lat, bc, nv, v, vl;
        clear_loop();
        kp = '0; ki = 16'd256; kd = '0; desired_pos = 10; actual_pos = 0;
        do_sample(lat, bc, nv, v, vl);
        checks++; if (v != 10) begin errors++; $display("FAIL en_abort_first: got %0d want 10", v); end
        nv = 0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (u_valid) nv++;
        end
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_abort_busy: got %b want 0", busy); end
        checks++; if (u_out !== 16'sd0) begin errors++; $display("FAIL en_abort_u_out: got %0d want 0", u_out); end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (u_valid) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL en_abort_no_valid: got %0d want 0", nv); end
        do_sample(lat, bc, nv, v, vl);
        checks++; if (v != 10) begin errors++; $display("FAIL en_abort_integ_cleared: got %0d want 10", v); end
    endtask

    initial begin
        test_reset();
        test_p_only();
        test_saturation();
        test_integrator();
        test_derivative();
        test_overrun();
        test_reset_abort();
        test_enable_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
